// File: rtl/key_event_controller_if.sv
// Key event controller bus: raw keys and frame clock in, interrupt/events/levels out.
// Latency: none (wiring only).
// Backpressure: interrupt is held until int_ack; new presses queue in the controller meanwhile.
//
// Ports carried:
//   key_in        raw asynchronous key levels, 1 = pressed
//   frame_rt_clk  divided frame clock, sampled as data
//   int_ack       CPU acknowledge
//   key_interrupt level interrupt to the CPU
//   key_events    presses delivered with the current interrupt
//   key_held      debounced key levels
//   frame_tick    one-cycle pulse per frame_rt_clk rising edge
interface key_event_controller_if #(
  parameter int NUM_KEYS = 4
);
  logic [NUM_KEYS-1:0] key_in;
  logic                frame_rt_clk;
  logic                int_ack;
  logic                key_interrupt;
  logic [NUM_KEYS-1:0] key_events;
  logic [NUM_KEYS-1:0] key_held;
  logic                frame_tick;

  // Controller side
  modport slave (
    input  key_in, frame_rt_clk, int_ack,
    output key_interrupt, key_events, key_held, frame_tick
  );

  // Board / CPU side
  modport master (
    output key_in, frame_rt_clk, int_ack,
    input  key_interrupt, key_events, key_held, frame_tick
  );
endinterface

// File: rtl/key_event_controller.sv
// Debounces NUM_KEYS push buttons and delivers collected presses to the CPU once per frame.
// Latency: key_held follows a clean input step after 2 + DEBOUNCE_CYCLES cycles; interrupt one cycle after frame_tick.
// Backpressure: while the interrupt awaits int_ack, new presses accumulate in a sticky pending set.
//
// Ports: sysclk (clock), reset (async active-high), bus (key_event_controller_if.slave:
//   key_in, frame_rt_clk, int_ack in; key_interrupt, key_events, key_held, frame_tick out).
// Optional feature: define KEY_EVENT_AUTO_REPEAT_EN to re-raise a held key every REPEAT_FRAMES frames.
module key_event_controller #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_FRAMES   = 15
) (
  input  logic                    sysclk,
  input  logic                    reset,
  key_event_controller_if.slave   bus
);

  if (NUM_KEYS < 1 || NUM_KEYS > 16 || DEBOUNCE_CYCLES < 1 || REPEAT_FRAMES < 1) begin : g_param_check
    $error("key_event_controller: parameter out of range");
  end

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {IDLE, WAIT_ACK} state_t;

  logic [NUM_KEYS-1:0] key_s1, key_s2;
  logic                frame_s1, frame_s2, frame_prev;
  logic                tick_q;
  logic [NUM_KEYS-1:0] held_q, held_nxt;
  logic [NUM_KEYS-1:0] rep_hit;
  logic [NUM_KEYS-1:0] new_evt;
  logic [NUM_KEYS-1:0] pending_q, pending_nxt;
  logic [NUM_KEYS-1:0] events_q, events_nxt;
  logic                irq_q, irq_nxt;
  state_t              state_q, state_nxt;

  // Two-flop synchronisers; frame_prev gives the edge detector its "seen 0" history.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      key_s1     <= '0;
      key_s2     <= '0;
      frame_s1   <= 1'b0;
      frame_s2   <= 1'b0;
      frame_prev <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      key_s1     <= bus.key_in;
      key_s2     <= key_s1;
      frame_s1   <= bus.frame_rt_clk;
      frame_s2   <= frame_s1;
      frame_prev <= frame_s2;
      tick_q     <= frame_s2 & ~frame_prev;
    end
  end

  // Per-key debounce: counts consecutive cycles of disagreement; the count saturates
  // into an accepted level change, so it never wraps.
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_debounce
    logic [CW-1:0] cnt;
    logic          differs;
    assign differs     = key_s2[i] ^ held_q[i];
    assign held_nxt[i] = (differs && cnt == DB_LAST) ? key_s2[i] : held_q[i];

    always_ff @(posedge sysclk or posedge reset) begin
      if (reset)                 cnt <= '0;
      else if (!differs)         cnt <= '0;
      else if (cnt == DB_LAST)   cnt <= '0;
      else                       cnt <= cnt + 1'b1;
    end
  end

`ifdef KEY_EVENT_AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_FRAMES + 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_FRAMES - 1);

  // Frame counter per held key; the REPEAT_FRAMES-th tick re-arms the key.
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_repeat
    logic [RW-1:0] rp_cnt;
    assign rep_hit[i] = held_q[i] & tick_q & (rp_cnt == RP_LAST);

    always_ff @(posedge sysclk or posedge reset) begin
      if (reset)            rp_cnt <= '0;
      else if (!held_q[i])  rp_cnt <= '0;
      else if (tick_q)      rp_cnt <= (rp_cnt == RP_LAST) ? '0 : rp_cnt + 1'b1;
    end
  end
`else
  assign rep_hit = '0;
`endif

  // Rising edges of the debounced level are presses; releases are silent.
  assign new_evt = (held_nxt & ~held_q) | rep_hit;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      held_q    <= '0;
      pending_q <= '0;
      events_q  <= '0;
      irq_q     <= 1'b0;
      state_q   <= IDLE;
    end else begin
      held_q    <= held_nxt;
      pending_q <= pending_nxt;
      events_q  <= events_nxt;
      irq_q     <= irq_nxt;
      state_q   <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state_q;
    irq_nxt     = irq_q;
    events_nxt  = events_q;
    pending_nxt = pending_q | new_evt;
    case (state_q)
      IDLE: begin
        if (tick_q && pending_q != '0) begin
          events_nxt  = pending_q;
          // Presses landing on the delivery edge stay queued for the next frame.
          pending_nxt = new_evt;
          irq_nxt     = 1'b1;
          state_nxt   = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        // Ack takes priority over a coincident frame tick; the tick is simply lost.
        if (bus.int_ack) begin
          events_nxt = '0;
          irq_nxt    = 1'b0;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.key_interrupt = irq_q;
  assign bus.key_events    = events_q;
  assign bus.key_held      = held_q;
  assign bus.frame_tick    = tick_q;

endmodule

// File: tb/tb_key_event_controller.sv
// Bench for key_event_controller: directed scenarios plus random key/ack traffic.
// Latency: reference model is updated at each clock edge, outputs compared 1 ns later.
// Backpressure: int_ack is driven directly or randomly by the bench.
module tb_key_event_controller;
  localparam int NK = 4;
  localparam int DB = 4;
  localparam int RF = 3;
  localparam int FP = 16;   // frame_rt_clk period in sysclk cycles

  logic sysclk = 1'b0;
  logic reset  = 1'b0;

  key_event_controller_if #(.NUM_KEYS(NK)) bus ();

  key_event_controller #(
    .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DB), .REPEAT_FRAMES(RF)
  ) dut (
    .sysclk(sysclk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 sysclk = ~sysclk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit frame_run = 1'b0;

  // Reference model: raw sample history, debounced level, pending set, outstanding interrupt.
  logic [NK-1:0] kh [0:DB+1];
  logic          fh [0:3];
  logic [NK-1:0] m_held, m_ev, m_pend;
  logic          m_irq, m_tick;
  int            m_k0_deliv = 0;
`ifdef KEY_EVENT_AUTO_REPEAT_EN
  int            fr [NK];
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j <= DB + 1; j++) kh[j] = '0;
    for (int j = 0; j < 4; j++) fh[j] = 1'b0;
    m_held = '0; m_ev = '0; m_pend = '0; m_irq = 1'b0; m_tick = 1'b0;
`ifdef KEY_EVENT_AUTO_REPEAT_EN
    for (int i = 0; i < NK; i++) fr[i] = 0;
`endif
  endtask

  task automatic model_step();
    logic [NK-1:0] hn, pr, rp;
    bit flip;
    for (int j = DB + 1; j > 0; j--) kh[j] = kh[j-1];
    kh[0] = bus.key_in;
    for (int j = 3; j > 0; j--) fh[j] = fh[j-1];
    fh[0] = bus.frame_rt_clk;
    // A key flips once the synchronised input has disagreed with it for DB straight cycles.
    hn = m_held;
    for (int i = 0; i < NK; i++) begin
      flip = 1'b1;
      for (int j = 2; j <= DB + 1; j++) if (kh[j][i] == m_held[i]) flip = 1'b0;
      if (flip) hn[i] = ~m_held[i];
    end
    pr = hn & ~m_held;
    rp = '0;
`ifdef KEY_EVENT_AUTO_REPEAT_EN
    for (int i = 0; i < NK; i++) begin
      if (!m_held[i]) fr[i] = 0;
      else if (m_tick) begin
        fr[i]++;
        if (fr[i] % RF == 0) rp[i] = 1'b1;
      end
    end
`endif
    if (!m_irq && m_tick && m_pend != '0) begin
      m_ev  = m_pend;
      m_irq = 1'b1;
      if (m_pend[0]) m_k0_deliv++;
      m_pend = '0;
    end else if (m_irq && bus.int_ack) begin
      m_irq = 1'b0;
      m_ev  = '0;
    end
    m_pend = m_pend | pr | rp;
    m_held = hn;
    m_tick = fh[2] & ~fh[3];
  endtask

  task automatic tick();
    @(posedge sysclk);
    if (reset) model_reset();
    else       model_step();
    #1;
    if (!reset) begin
      chk("cyc_irq",  bus.key_interrupt, m_irq);
      chk("cyc_ev",   bus.key_events,    m_ev);
      chk("cyc_held", bus.key_held,      m_held);
      chk("cyc_tick", bus.frame_tick,    m_tick);
    end
    cyc++;
    bus.frame_rt_clk = frame_run && (((cyc / (FP / 2)) % 2) == 1);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_irq",  bus.key_interrupt, 0);
    chk("rst_ev",   bus.key_events,    0);
    chk("rst_held", bus.key_held,      0);
    chk("rst_tick", bus.frame_tick,    0);
    model_reset();
    ticks(3);
    reset = 1'b0;
  endtask

  task automatic wait_irq(input int max);
    bit got;
    int k;
    got = bus.key_interrupt;
    k = 0;
    while (!got && k < max) begin
      tick();
      got = bus.key_interrupt;
      k++;
    end
    chk("irq_wait", got, 1);
  endtask

  task automatic ack_pulse();
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
  endtask

  // Run n cycles acknowledging any interrupt straight away.
  task automatic drain(input int n);
    for (int k = 0; k < n; k++) begin
      bus.int_ack = bus.key_interrupt;
      tick();
    end
    bus.int_ack = 1'b0;
  endtask

  initial begin
    bit got;
    int n0, m0;
    bus.key_in = '0;
    bus.frame_rt_clk = 1'b0;
    bus.int_ack = 1'b0;
    model_reset();
    #2;
    do_reset();
    frame_run = 1'b1;

    // Clean step on key 0: debounced level after exactly 2 + DB edges, then delivery.
    bus.key_in = 4'b0001;
    ticks(5);
    chk("held_early", bus.key_held[0], 0);
    tick();
    chk("held_on_time", bus.key_held[0], 1);
    wait_irq(3 * FP);
    chk("ev_key0", bus.key_events, 4'b0001);
    ack_pulse();
    chk("ack_drop", bus.key_interrupt, 0);
    bus.key_in = '0;
    drain(3 * FP);

    // Short glitches on key 1 never pass the debounce.
    for (int r = 0; r < 5; r++) begin
      bus.key_in = 4'b0010;
      ticks(3);
      bus.key_in = 4'b0000;
      ticks(3);
    end
    ticks(3 * FP);
    chk("glitch_held", bus.key_held, 0);
    chk("glitch_irq",  bus.key_interrupt, 0);

    // Press during an outstanding interrupt waits for the ack and the next frame.
    bus.key_in = 4'b0001;
    wait_irq(4 * FP);
    chk("ev_first", bus.key_events, 4'b0001);
    bus.key_in = 4'b0101;
    ticks(2 * FP);
    chk("ev_held_off", bus.key_events, 4'b0001);
    chk("irq_held_off", bus.key_interrupt, 1);
    ack_pulse();
    chk("ack_drop2", bus.key_interrupt, 0);
    wait_irq(2 * FP);
    chk("ev_key2_bit", bus.key_events & 4'b0100, 4'b0100);
`ifndef KEY_EVENT_AUTO_REPEAT_EN
    chk("ev_key2", bus.key_events, 4'b0100);
`endif
    ack_pulse();
    bus.key_in = '0;
    drain(3 * FP);

    // Ack coinciding with frame_tick: ack wins, pending key 3 goes out next frame.
    bus.key_in = 4'b0001;
    wait_irq(4 * FP);
    bus.key_in = 4'b1001;
    ticks(10);
    got = 1'b0;
    for (int k = 0; k < 2 * FP && !got; k++) begin
      tick();
      got = bus.frame_tick;
    end
    chk("tick_seen", got, 1);
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    chk("ack_tick_irq", bus.key_interrupt, 0);
    chk("ack_tick_ev",  bus.key_events, 0);
    wait_irq(2 * FP);
    chk("ev_key3_bit", bus.key_events & 4'b1000, 4'b1000);
`ifndef KEY_EVENT_AUTO_REPEAT_EN
    chk("ev_key3", bus.key_events, 4'b1000);
`endif
    ack_pulse();
    bus.key_in = '0;
    drain(3 * FP);

    // Random key traffic and acks, including acks while idle.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        int b;
        b = $urandom_range(0, NK - 1);
        bus.key_in[b] = ~bus.key_in[b];
      end
      bus.int_ack = ($urandom_range(0, 4) == 0);
      tick();
    end
    bus.key_in = '0;
    bus.int_ack = 1'b0;
    drain(3 * FP);

    // Reset while the interrupt is up clears everything before the next edge.
    bus.key_in = 4'b0001;
    wait_irq(4 * FP);
    chk("pre_rst_irq", bus.key_interrupt, 1);
    do_reset();
    bus.key_in = '0;
    drain(2 * FP);

    // Key 0 held for 10 frames, every interrupt acked at once.
    n0 = 0;
    m0 = m_k0_deliv;
    bus.key_in = 4'b0001;
    for (int c = 0; c < 10 * FP; c++) begin
      if (bus.key_interrupt && bus.key_events[0]) n0++;
      bus.int_ack = bus.key_interrupt;
      tick();
    end
    bus.key_in = '0;
    for (int c = 0; c < 3 * FP; c++) begin
      if (bus.key_interrupt && bus.key_events[0]) n0++;
      bus.int_ack = bus.key_interrupt;
      tick();
    end
    bus.int_ack = 1'b0;
    chk("hold_events", n0, m_k0_deliv - m0);
`ifdef KEY_EVENT_AUTO_REPEAT_EN
    chk("hold_repeats_seen", (n0 >= 3) ? 1 : 0, 1);
`else
    chk("hold_single_event", n0, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule
